cdb_broadcaster: RTL and testbench

Transmit side of the common data bus (CDB) in the out-of-order core. Collects completed results (tag, data) from the functional units, arbitrates round-robin among them and drives one registered broadcast per cycle on `cdb_valid`/`cdb_tag`/`cdb_data`. The register status table, reservation stations and register file consume these broadcasts. A one-entry holding register per functional unit decouples completion from bus grant.

---
 rtl/cdb_pkg.sv | 16 +
 rtl/cdb_broadcaster_if.sv | 31 +++
 rtl/cdb_broadcaster_arbiter.sv | 31 +++
 rtl/cdb_broadcaster.sv | 94 +++++++++
 tb/tb_cdb_broadcaster.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default bus geometry and functional-unit index names,
// common to the broadcaster, status table and reservation stations.
package cdb_pkg;

  localparam int CDB_NUM_FU = 4;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MUL  = 2'd2,
    FU_LSU  = 2'd3
  } fu_id_e;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Functional-unit result ports and CDB broadcast bus. The broadcaster uses the
// slave view; the functional units / consumers side uses the master view.
interface cdb_broadcaster_if
  import cdb_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [IDX_W-1:0]         cdb_src;

  modport master (
    output fu_valid, fu_tag, fu_data,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  fu_valid, fu_tag, fu_data,
    output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_broadcaster_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N. Also reused by the issue logic.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[IW'(j)]) begin
        any              = 1'b1;
        grant[IW'(j)]    = 1'b1;
        grant_idx        = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one holding register per functional unit, round-robin
// selection among occupied entries, one registered broadcast per cycle.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  cdb_broadcaster_if.slave bus
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] occ_p0;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] accept;
  logic [TAG_W-1:0]  hold_tag_p0  [NUM_FU];
  logic [DATA_W-1:0] hold_data_p0 [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  ptr_next;
  logic              any;

  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] data_p1;
  logic [IDX_W-1:0]  src_p1;

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .req       (occ_p0),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // A granted entry drains at this edge, so it may be refilled in the same cycle.
  assign ready    = {NUM_FU{~rst & ~flush}} & (~occ_p0 | grant);
  assign accept   = bus.fu_valid & ready;
  assign ptr_next = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  // Stage p0: holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_p0 <= '0;
    end else if (flush) begin
      occ_p0 <= '0;
    end else begin
      occ_p0 <= (occ_p0 & ~grant) | accept;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        hold_tag_p0[i]  <= bus.fu_tag[i*TAG_W +: TAG_W];
        hold_data_p0[i] <= bus.fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: registered broadcast; payload holds when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= any;
      if (any) begin
        tag_p1  <= hold_tag_p0[grant_idx];
        data_p1 <= hold_data_p0[grant_idx];
        src_p1  <= grant_idx;
        rr_ptr  <= ptr_next;
      end
    end
  end

  assign bus.fu_ready  = ready;
  assign bus.cdb_valid = vld_p1;
  assign bus.cdb_tag   = tag_p1;
  assign bus.cdb_data  = data_p1;
  assign bus.cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios plus random traffic, checked
// every cycle against an array-based model of the holding slots and pointer.
module tb_cdb_broadcaster;

  localparam int NF = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_broadcaster #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  bit              m_occ  [NF];
  logic [TW-1:0]   m_tag  [NF];
  logic [DW-1:0]   m_data [NF];
  int              m_ptr;
  logic            e_vld;
  logic [TW-1:0]   e_tag;
  logic [DW-1:0]   e_data;
  int              e_src;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NF; k++)
      if (m_occ[(m_ptr + k) % NF]) return (m_ptr + k) % NF;
    return -1;
  endfunction

  function automatic logic [NF-1:0] exp_ready(input logic fl);
    int g;
    logic [NF-1:0] r;
    g = pick();
    for (int i = 0; i < NF; i++) r[i] = !fl && (!m_occ[i] || i == g);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_occ[i] = 1'b0;
    m_ptr  = 0;
    e_vld  = 1'b0;
    e_tag  = '0;
    e_data = '0;
    e_src  = 0;
  endtask

  task automatic model_edge(input logic [NF-1:0] v, input logic [NF*TW-1:0] t,
                            input logic [NF*DW-1:0] d, input logic fl);
    int g;
    logic [NF-1:0] r;
    g = pick();
    r = exp_ready(fl);
    if (fl) begin
      for (int i = 0; i < NF; i++) m_occ[i] = 1'b0;
      e_vld = 1'b0;
    end else begin
      if (g >= 0) begin
        e_vld    = 1'b1;
        e_tag    = m_tag[g];
        e_data   = m_data[g];
        e_src    = g;
        m_ptr    = (g + 1) % NF;
        m_occ[g] = 1'b0;
      end else begin
        e_vld = 1'b0;
      end
      for (int i = 0; i < NF; i++) begin
        if (v[i] && r[i]) begin
          m_occ[i]  = 1'b1;
          m_tag[i]  = t[i*TW +: TW];
          m_data[i] = d[i*DW +: DW];
        end
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic [NF-1:0] v, input logic [NF*TW-1:0] t,
                       input logic [NF*DW-1:0] d, input logic fl);
    bus.fu_valid = v;
    bus.fu_tag   = t;
    bus.fu_data  = d;
    flush        = fl;
    #1;
    chk("fu_ready", 64'(bus.fu_ready), 64'(exp_ready(fl)));
    @(posedge clk);
    model_edge(v, t, d, fl);
    #1;
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(e_vld));
    chk("cdb_tag", 64'(bus.cdb_tag), 64'(e_tag));
    chk("cdb_data", 64'(bus.cdb_data), 64'(e_data));
    chk("cdb_src", 64'(bus.cdb_src), 64'(e_src));
    @(negedge clk);
    bus.fu_valid = '0;
    flush        = 1'b0;
  endtask

  task automatic idle();
    cycle('0, '0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_tag", 64'(bus.cdb_tag), 64'd0);
    chk("rst_data", 64'(bus.cdb_data), 64'd0);
    chk("rst_src", 64'(bus.cdb_src), 64'd0);
    chk("rst_ready", 64'(bus.fu_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NF*TW-1:0] t;
  logic [NF*DW-1:0] d;
  logic             seen3;

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    bus.fu_valid = '0;
    bus.fu_tag   = '0;
    bus.fu_data  = '0;
    model_reset();
    #1;
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_ready", 64'(bus.fu_ready), 64'd0);
    chk("rst_tag", 64'(bus.cdb_tag), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    repeat (3) idle();
    chk("idle_valid", 64'(bus.cdb_valid), 64'd0);
    chk("idle_ready", 64'(bus.fu_ready), 64'hF);

    // Single result on FU2
    t = '0; d = '0;
    t[2*TW +: TW] = 6'h15;
    d[2*DW +: DW] = 32'hDEADBEEF;
    cycle(4'b0100, t, d, 1'b0);
    chk("single_early", 64'(bus.cdb_valid), 64'd0);
    idle();
    chk("single_valid", 64'(bus.cdb_valid), 64'd1);
    chk("single_tag", 64'(bus.cdb_tag), 64'h15);
    chk("single_data", 64'(bus.cdb_data), 64'hDEADBEEF);
    chk("single_src", 64'(bus.cdb_src), 64'd2);
    idle();
    chk("single_after", 64'(bus.cdb_valid), 64'd0);

    // All four at once from pointer 0
    pulse_reset();
    t = {6'd4, 6'd3, 6'd2, 6'd1};
    d = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    cycle(4'b1111, t, d, 1'b0);
    for (int k = 0; k < NF; k++) begin
      idle();
      chk("all4_tag", 64'(bus.cdb_tag), 64'(k + 1));
      chk("all4_src", 64'(bus.cdb_src), 64'(k));
    end
    idle();

    // Fairness: FU0 streams, FU3 arrives once
    seen3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      t = '0; d = '0;
      t[0 +: TW] = TW'(6'h30 + k);
      d[0 +: DW] = 32'hA000_0000 + k;
      t[3*TW +: TW] = 6'h3F;
      d[3*DW +: DW] = 32'h0BAD_F00D;
      cycle((k == 0) ? 4'b1001 : 4'b0001, t, d, 1'b0);
      if (k < 4 && bus.cdb_valid && bus.cdb_src == 2'd3) seen3 = 1'b1;
    end
    chk("fair_fu3", 64'(seen3), 64'd1);
    repeat (3) idle();

    // Grant and refill on FU1 in the same cycle
    t = '0; d = '0;
    t[1*TW +: TW] = 6'h11;
    d[1*DW +: DW] = 32'h0000_1111;
    cycle(4'b0010, t, d, 1'b0);
    t[1*TW +: TW] = 6'h22;
    d[1*DW +: DW] = 32'h0000_2222;
    cycle(4'b0010, t, d, 1'b0);
    chk("refill_old", 64'(bus.cdb_tag), 64'h11);
    idle();
    chk("refill_new", 64'(bus.cdb_tag), 64'h22);
    chk("refill_src", 64'(bus.cdb_src), 64'd1);
    chk("refill_vld", 64'(bus.cdb_valid), 64'd1);
    idle();

    // Flush with three entries pending
    t = {6'h00, 6'h2C, 6'h2B, 6'h2A};
    d = {32'h0, 32'hC, 32'hB, 32'hA};
    cycle(4'b0111, t, d, 1'b0);
    cycle('0, '0, '0, 1'b1);
    chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("flush_stale", 64'(bus.cdb_valid), 64'd0);
    end

    // Async reset mid-burst
    t = {6'h34, 6'h33, 6'h32, 6'h31};
    cycle(4'b1111, t, d, 1'b0);
    idle();
    pulse_reset();
    repeat (2) idle();
    chk("post_rst_valid", 64'(bus.cdb_valid), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NF; i++) begin
        t[i*TW +: TW] = TW'($urandom);
        d[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 149) == 0) pulse_reset();
      cycle(NF'($urandom), t, d, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
